servo_pwm_multi: RTL and testbench
==================================

# servo_pwm_multi

Parametrised multi-channel servo PWM generator with per-channel target clamping and slew-rate limiting. It replaces the per-axis steering blocks: the joystick SPI front-ends feed microsecond pulse-width targets in, and one PWM output per servo comes out. All channels share one frame timebase, so their pulses start on the same microsecond. A channel reaches a new target gradually, in bounded steps per frame, so servos never see a step demand.

## Interface
Parameters:
- CLK_HZ, 100_000_000: system clock frequency. Must be an integer multiple of 1_000_000.
- N_CH, 3: number of servo channels, 1..16.
- PW_W, 12: width of the pulse-width fields, in microseconds.
- PERIOD_US, 20000: frame length in µs.
- PW_MIN, 1000: lower clamp on pulse width, in µs.
- PW_MAX, 2000: upper clamp on pulse width, in µs. Must satisfy PW_MIN ≤ PW_MAX < PERIOD_US and PW_MAX < 2^PW_W.
- SLEW_US, 4: maximum change in pulse width per frame, in µs. A value of 0 disables slew limiting, so targets apply in full at the next frame.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-low reset.
- pw_target  in  N_CH*PW_W  per-channel target width in µs. Channel i occupies bits [i*PW_W +: PW_W].
- target_valid  in  N_CH  per-channel load strobe. When bit i is 1 for a cycle, field i is latched.
- enable  in  N_CH  per-channel output enable. Sampled only at frame boundaries.
- pwm  out  N_CH  servo pulse outputs.
- frame_start  out  1  one-cycle pulse marking the start of each frame.
- pw_current  out  N_CH*PW_W  width currently being generated on each channel.
- at_target  out  N_CH  per-channel flag: 1 when the current width equals the latched target.

## Operation
- Prescaler: counts 0..DIV-1, where DIV = CLK_HZ/1_000_000, then wraps to 0.
  - tick = (presc == DIV-1).
- Microsecond counter us_cnt: counts 0..PERIOD_US-1. It increments on tick and wraps to 0.
- Boundary condition: bnd = (presc == 0 && us_cnt == 0).
- Target latch: when target_valid[i] is 1, tgt[i] takes the clamped input.
  - Clamping: an input below PW_MIN becomes PW_MIN; above PW_MAX becomes PW_MAX; otherwise it passes unchanged.
  - A new target is latched at any time, but it only affects output at a frame boundary.
- Slew step: on the cycle where bnd is 1, each cur[i] moves toward the pre-edge value of tgt[i].
  - If |tgt-cur| ≤ SLEW_US, or SLEW_US = 0: cur becomes tgt.
  - Otherwise cur moves by ±SLEW_US toward tgt.
  - The difference is computed signed, on PW_W+1 bits.
- Simultaneous target_valid and bnd: the step uses the old tgt. The new target is used from the next frame onward.
- Enable: en_f[i] is loaded from enable[i] when bnd is 1, and held for the whole frame.
  - A disabled channel freezes cur[i] (no slew step) and holds pwm[i] low.
  - Toggling enable mid-frame never truncates or produces a partial pulse.
- Output compare: pwm[i] is registered as en_f[i] && (us_cnt < cur[i]), using the post-step cur.

## Timing
- Reset (rst = 0 at a clock edge) sets:
  - presc = 0, us_cnt = 0.
  - cur and tgt = PW_CTR, where PW_CTR = (PW_MIN+PW_MAX)/2, floored.
  - en_f = 0.
  - pwm = 0, frame_start = 0, at_target = all 1, pw_current = PW_CTR.
- First frame: bnd is true in the first cycle after rst returns high. frame_start rises one cycle later.
- All outputs are registered, so there is 1 clock of latency from the counter state.
  - pwm[i] rises together with frame_start.
  - pwm[i] stays high for exactly cur[i]*DIV clocks.
- Frames are exactly PERIOD_US*DIV clocks long. frame_start pulses are spaced by that amount.
- Target-to-output latency: the new width starts at the first frame boundary after the strobe.
- A full move takes ceil(|Δ|/SLEW_US) frames.
- at_target and pw_current update in the cycle after a step or a target latch.
- Reset asserted mid-pulse: pwm is 0 at the next edge. There is no completion of the partial frame.
- Counter wrap: after us_cnt = PERIOD_US-1, the next tick returns it to 0 and bnd follows.

## Test plan
Bench parameters: CLK_HZ=1_000_000 (DIV=1), PERIOD_US=2500, N_CH=3, SLEW_US=4.
- Reset, then enable = 3'b111 with no targets loaded: every pwm is high for 1500 clocks per 2500-clock frame; at_target = 3'b111.
- Target ch0 = 2000 loaded mid-frame: widths run 1504, 1508, …; width 2000 is reached in frame 125; at_target[0] goes to 1 then; ch1 and ch2 stay at 1500.
- Targets of 2600 and 300 on ch1: pw_current saturates at 2000 and 1000 respectively; the width never leaves [1000, 2000].
- target_valid strobe on the same cycle as bnd: the step taken at that boundary uses the old target; the new target applies at the next boundary.
- enable[2] dropped 200 clocks into a pulse: the pulse completes at full width; the next frame has pwm[2] = 0 and cur[2] frozen; re-enabling resumes at the frozen width.
- rst pulled low at clock 700 of a 1500 µs pulse: pwm = 0 on the next edge; after release, widths are back to 1500 and frame_start is re-aligned.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM generator.
// All channels share one prescaler and one microsecond frame counter, so their
// pulses start on the same microsecond. Each channel keeps a clamped target
// width and a current width. The current width moves toward the target by at
// most SLEW_US at every frame boundary.
module servo_pwm_multi #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int N_CH      = 3,
  parameter int PW_W      = 12,
  parameter int PERIOD_US = 20000,
  parameter int PW_MIN    = 1000,
  parameter int PW_MAX    = 2000,
  parameter int SLEW_US   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*PW_W-1:0]   pw_target,
  input  logic [N_CH-1:0]        target_valid,
  input  logic [N_CH-1:0]        enable,
  output logic [N_CH-1:0]        pwm,
  output logic                   frame_start,
  output logic [N_CH*PW_W-1:0]   pw_current,
  output logic [N_CH-1:0]        at_target
);

  localparam int DIV     = CLK_HZ / 1_000_000;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int US_W    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int CMP_W   = (US_W > PW_W) ? US_W : PW_W;
  localparam int DW      = PW_W + 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [US_W-1:0]    US_LAST    = US_W'(PERIOD_US - 1);
  localparam logic [PW_W-1:0]    PW_MIN_V   = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0]    PW_MAX_V   = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0]    PW_CTR_V   = PW_W'((PW_MIN + PW_MAX) / 2);
  localparam logic [PW_W-1:0]    SLEW_PW    = PW_W'(SLEW_US);
  localparam logic [DW-1:0]      SLEW_MAG   = DW'(SLEW_US);
  localparam bit                 SLEW_OFF   = (SLEW_US == 0);

  // Clamp a requested width into [PW_MIN, PW_MAX].
  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] v);
    logic [PW_W-1:0] r;
    if (v < PW_MIN_V) begin
      r = PW_MIN_V;
    end else if (v > PW_MAX_V) begin
      r = PW_MAX_V;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One slew step of current width c toward target t. The difference is taken
  // signed on PW_W+1 bits so any pair of PW_W-bit widths is representable.
  function automatic logic [PW_W-1:0] slew_step(input logic [PW_W-1:0] c,
                                                input logic [PW_W-1:0] t);
    logic signed [DW-1:0] d;
    logic [DW-1:0]        mag;
    logic [PW_W-1:0]      r;
    d = $signed({1'b0, t}) - $signed({1'b0, c});
    if (d[DW-1]) begin
      mag = $unsigned(-d);
    end else begin
      mag = $unsigned(d);
    end
    if (SLEW_OFF || (mag <= SLEW_MAG)) begin
      r = t;
    end else if (d[DW-1]) begin
      r = c - SLEW_PW;
    end else begin
      r = c + SLEW_PW;
    end
    return r;
  endfunction

  logic [PRESC_W-1:0] presc_r;
  logic [US_W-1:0]    us_cnt_r;
  logic [PW_W-1:0]    tgt_r    [N_CH];
  logic [PW_W-1:0]    cur_r    [N_CH];
  logic [N_CH-1:0]    en_f_r;

  logic               tick_s;
  logic               bnd_s;
  logic [PW_W-1:0]    tgt_nx_s [N_CH];
  logic [PW_W-1:0]    cur_nx_s [N_CH];
  logic [N_CH-1:0]    en_nx_s;
  logic [N_CH-1:0]    pwm_nx_s;
  logic [N_CH-1:0]    at_nx_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign bnd_s  = (presc_r == '0) && (us_cnt_r == '0);

  // Frame timebase: prescaler to 1 us, then microsecond counter over the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_r  <= '0;
      us_cnt_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
      if (us_cnt_r == US_LAST) begin
        us_cnt_r <= '0;
      end else begin
        us_cnt_r <= us_cnt_r + US_W'(1);
      end
    end else begin
      presc_r  <= presc_r + PRESC_W'(1);
      us_cnt_r <= us_cnt_r;
    end
  end

  // Next-state of per-channel targets, widths, enables and output compares.
  // The slew step reads the pre-edge target and the enable of the frame that
  // is ending, so a re-enabled channel resumes exactly at its frozen width.
  always_comb begin
    en_nx_s  = bnd_s ? enable : en_f_r;
    pwm_nx_s = '0;
    at_nx_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (target_valid[i]) begin
        tgt_nx_s[i] = clamp_pw(pw_target[i*PW_W +: PW_W]);
      end else begin
        tgt_nx_s[i] = tgt_r[i];
      end
      if (bnd_s && en_f_r[i]) begin
        cur_nx_s[i] = slew_step(cur_r[i], tgt_r[i]);
      end else begin
        cur_nx_s[i] = cur_r[i];
      end
      pwm_nx_s[i] = en_nx_s[i] && (CMP_W'(us_cnt_r) < CMP_W'(cur_nx_s[i]));
      at_nx_s[i]  = (cur_nx_s[i] == tgt_nx_s[i]);
    end
  end

  // Per-channel state: latched targets, current widths, frame-sampled enables.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        tgt_r[i] <= PW_CTR_V;
        cur_r[i] <= PW_CTR_V;
      end
      en_f_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        tgt_r[i] <= tgt_nx_s[i];
        cur_r[i] <= cur_nx_s[i];
      end
      en_f_r <= en_nx_s;
    end
  end

  // Registered outputs; pwm and frame_start rise on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm         <= '0;
      frame_start <= 1'b0;
      at_target   <= '1;
      for (int i = 0; i < N_CH; i++) begin
        pw_current[i*PW_W +: PW_W] <= PW_CTR_V;
      end
    end else begin
      pwm         <= pwm_nx_s;
      frame_start <= bnd_s;
      at_target   <= at_nx_s;
      for (int i = 0; i < N_CH; i++) begin
        pw_current[i*PW_W +: PW_W] <= cur_nx_s[i];
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Testbench for servo_pwm_multi with DIV=1, a 2500 us frame and 3 channels.
// A frame-level behavioural model predicts every output on every cycle, and
// directed phases pin pulse widths, slew sequences and reset behaviour with
// hand-computed constants.
module tb_servo_pwm_multi;
  localparam int CLK_HZ = 1_000_000;
  localparam int N_CH   = 3;
  localparam int PW_W   = 12;
  localparam int PER    = 2500;
  localparam int PMIN   = 1000;
  localparam int PMAX   = 2000;
  localparam int SLEW   = 4;
  localparam int CTR    = (PMIN + PMAX) / 2;

  logic                 clk;
  logic                 rst;
  logic [N_CH*PW_W-1:0] pw_target;
  logic [N_CH-1:0]      target_valid;
  logic [N_CH-1:0]      enable;
  logic [N_CH-1:0]      pwm;
  logic                 frame_start;
  logic [N_CH*PW_W-1:0] pw_current;
  logic [N_CH-1:0]      at_target;

  int checks = 0;
  int errors = 0;

  servo_pwm_multi #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .PW_W(PW_W), .PERIOD_US(PER),
    .PW_MIN(PMIN), .PW_MAX(PMAX), .SLEW_US(SLEW)
  ) dut (
    .clk(clk), .rst(rst), .pw_target(pw_target), .target_valid(target_valid),
    .enable(enable), .pwm(pwm), .frame_start(frame_start),
    .pw_current(pw_current), .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: position within the frame, widths, targets, frame enables.
  int          m_pos;
  int          m_cur [N_CH];
  int          m_tgt [N_CH];
  logic [2:0]  m_en;
  logic [2:0]  e_pwm;
  logic [2:0]  e_at;
  logic        e_fs;
  logic [35:0] e_pwc;
  bit          m_valid = 1'b0;

  // Pulse-width monitor: high cycles per channel in the last complete frame.
  int hi [N_CH];
  int last_w [N_CH];
  int cyc = 0;
  int last_per = 0;

  function automatic int clampf(input int v);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  function automatic int pwc(input int ch);
    return int'(pw_current[ch*PW_W +: PW_W]);
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_tgt(input int ch, input int v);
    pw_target[ch*PW_W +: PW_W] = 12'(v);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 3000);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_timeout actual=none required=pulse_within_3000 t=%0t", $time);
    end
  endtask

  // Behavioural model: at a frame start each channel that was enabled in the
  // ending frame steps toward its old target, then the new enables are taken;
  // a channel's pulse is high while the frame position is below its width.
  initial begin
    bit bnd;
    int d;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_pos = 0;
        m_en  = 3'b000;
        for (int i = 0; i < N_CH; i++) begin
          m_cur[i] = CTR;
          m_tgt[i] = CTR;
        end
        e_fs  = 1'b0;
        e_pwm = 3'b000;
      end else begin
        bnd = (m_pos == 0);
        if (bnd) begin
          for (int i = 0; i < N_CH; i++) begin
            if (m_en[i]) begin
              d = m_tgt[i] - m_cur[i];
              if (d <= SLEW && d >= -SLEW) m_cur[i] = m_tgt[i];
              else m_cur[i] = m_cur[i] + ((d > 0) ? SLEW : -SLEW);
            end
          end
          m_en = enable;
        end
        for (int i = 0; i < N_CH; i++) begin
          if (target_valid[i]) m_tgt[i] = clampf(int'(pw_target[i*PW_W +: PW_W]));
        end
        e_fs = bnd;
        for (int i = 0; i < N_CH; i++) e_pwm[i] = m_en[i] && (m_pos < m_cur[i]);
        m_pos = (m_pos + 1) % PER;
      end
      for (int i = 0; i < N_CH; i++) begin
        e_at[i] = (m_cur[i] == m_tgt[i]);
        e_pwc[i*PW_W +: PW_W] = 12'(m_cur[i]);
      end
      m_valid = 1'b1;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check_eq("pwm", 64'(pwm), 64'(e_pwm));
        check_eq("frame_start", 64'(frame_start), 64'(e_fs));
        check_eq("pw_current", 64'(pw_current), 64'(e_pwc));
        check_eq("at_target", 64'(at_target), 64'(e_at));
      end
    end
  end

  // Frame monitor for pulse widths and frame spacing.
  initial begin
    for (int i = 0; i < N_CH; i++) begin
      hi[i] = 0;
      last_w[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        for (int i = 0; i < N_CH; i++) begin
          last_w[i] = hi[i];
          hi[i] = (pwm[i] === 1'b1) ? 1 : 0;
        end
        last_per = cyc;
        cyc = 1;
      end else begin
        for (int i = 0; i < N_CH; i++) hi[i] += (pwm[i] === 1'b1) ? 1 : 0;
        cyc++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wk;
    int frozen;
    rst = 1'b0;
    pw_target = '0;
    target_valid = 3'b000;
    enable = 3'b000;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", 64'(pwm), 64'd0);
    check_eq("rst_at_target", 64'(at_target), 64'd7);
    check_eq("rst_frame_start", 64'(frame_start), 64'd0);
    check_eq("rst_pw_current", 64'(pw_current), 64'({12'd1500, 12'd1500, 12'd1500}));

    // Idle widths with all channels enabled.
    rst = 1'b1;
    enable = 3'b111;
    wait_fs(n);
    check_eq("first_frame_latency", 64'(n), 64'd1);
    wait_fs(n);
    #1;
    check_eq("frame_period", 64'(last_per), 64'd2500);
    for (int i = 0; i < N_CH; i++) check_eq("idle_width", 64'(last_w[i]), 64'd1500);

    // Mid-frame targets: ch0 -> 1540, ch2 -> 1600.
    repeat (300) @(negedge clk);
    set_tgt(0, 1540);
    set_tgt(2, 1600);
    target_valid = 3'b101;
    @(negedge clk);
    target_valid = 3'b000;
    check_eq("at_target_after_latch", 64'(at_target), 64'b010);
    wait_fs(n);
    #1;
    check_eq("ch0_first_step", 64'(pwc(0)), 64'd1504);
    check_eq("ch1_unchanged", 64'(pwc(1)), 64'd1500);
    check_eq("ch2_first_step", 64'(pwc(2)), 64'd1504);
    wait_fs(n);
    #1;
    check_eq("ch0_width_1504", 64'(last_w[0]), 64'd1504);
    repeat (8) wait_fs(n);
    #1;
    check_eq("ch0_reached", 64'(pwc(0)), 64'd1540);
    check_eq("ch0_at_target", 64'(at_target[0]), 64'd1);
    check_eq("ch2_still_moving", 64'(pwc(2)), 64'd1540);

    // Strobe exactly on the boundary cycle: old target used for that step.
    n = 0;
    while (m_pos != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    set_tgt(0, 1560);
    target_valid = 3'b001;
    @(negedge clk);
    target_valid = 3'b000;
    check_eq("bnd_strobe_fs", 64'(frame_start), 64'd1);
    check_eq("bnd_strobe_old_tgt", 64'(pwc(0)), 64'd1540);
    wait_fs(n);
    #1;
    check_eq("bnd_strobe_new_tgt", 64'(pwc(0)), 64'd1544);

    // Drop enable[2] 200 clocks into a pulse, then re-enable.
    wait_fs(n);
    repeat (200) @(negedge clk);
    enable = 3'b011;
    wk = m_cur[2];
    check_eq("ch2_width_pin", 64'(wk), 64'd1552);
    wait_fs(n);
    #1;
    check_eq("ch2_full_pulse", 64'(last_w[2]), 64'(wk));
    frozen = m_cur[2];
    check_eq("ch2_frozen_pin", 64'(frozen), 64'd1556);
    wait_fs(n);
    #1;
    check_eq("ch2_disabled_width", 64'(last_w[2]), 64'd0);
    check_eq("ch2_frozen", 64'(pwc(2)), 64'(frozen));
    repeat (100) @(negedge clk);
    enable = 3'b111;
    wait_fs(n);
    wait_fs(n);
    #1;
    check_eq("ch2_resume_width", 64'(last_w[2]), 64'(frozen));

    // Randomized targets (full 12-bit range, so clamping is exercised) and enables.
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      target_valid = 3'b000;
      if ($urandom_range(0, 399) == 0) begin
        target_valid = 3'($urandom_range(1, 7));
        for (int i = 0; i < N_CH; i++) set_tgt(i, int'($urandom_range(0, 4095)));
      end
      if ($urandom_range(0, 2999) == 0) enable = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    target_valid = 3'b000;
    enable = 3'b111;
    for (int i = 0; i < N_CH; i++) begin
      check_eq("cur_in_range", 64'((pwc(i) >= PMIN) && (pwc(i) <= PMAX)), 64'd1);
    end

    // Reset 700 clocks into a frame.
    wait_fs(n);
    repeat (699) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_pwm", 64'(pwm), 64'd0);
    check_eq("mid_rst_pw_current", 64'(pw_current), 64'({12'd1500, 12'd1500, 12'd1500}));
    check_eq("mid_rst_at_target", 64'(at_target), 64'd7);
    @(negedge clk);
    rst = 1'b1;
    wait_fs(n);
    check_eq("realign_latency", 64'(n), 64'd1);
    wait_fs(n);
    #1;
    check_eq("realign_period", 64'(last_per), 64'd2500);
    for (int i = 0; i < N_CH; i++) check_eq("realign_width", 64'(last_w[i]), 64'd1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
